// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider, run/freeze enable and
// line/frame strobes. Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned CLK_DIV = 2,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned CW      = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pixel_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
`ifdef VGA_FRAME_CNT_EN
  output logic          frame_start,
  output logic [15:0]   frame_count
`else
  output logic          frame_start
`endif
);

  localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HLast   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] VLast   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HDisp   = CW'(H_DISP);
  localparam logic [CW-1:0] VDisp   = CW'(V_DISP);
  localparam logic [CW-1:0] HSyncLo = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HSyncHi = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VSyncLo = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VSyncHi = CW'(V_DISP + V_FP + V_SYNC - 1);

  // Counters must be able to hold H_TOT-1 and V_TOT-1 without aliasing.
  if ((64'd1 << CW) <= 64'(H_TOT) || (64'd1 << CW) <= 64'(V_TOT)) begin : g_cw_check
    $error("vga_timing_gen: CW=%0d too narrow for H_TOT=%0d / V_TOT=%0d", CW, H_TOT, V_TOT);
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          tick, h_last, v_last, line_end, frame_end;

  logic          pixel_tick_q, hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic          hsync_d, vsync_d, video_on_d;
  logic [CW-1:0] pixel_x_q, pixel_y_q, pixel_x_d, pixel_y_d;

  always_comb begin
    tick      = enable && (div_q == DivLast);
    h_last    = (h_q == HLast);
    v_last    = (v_q == VLast);
    line_end  = tick && h_last;
    frame_end = line_end && v_last;

    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
    end
    h_d = h_q;
    if (tick) begin
      h_d = h_last ? '0 : h_q + 1'b1;
    end
    v_d = v_q;
    if (line_end) begin
      v_d = v_last ? '0 : v_q + 1'b1;
    end

    // Visible outputs are decoded from the pre-update counters and frozen while disabled.
    pixel_x_d  = pixel_x_q;
    pixel_y_d  = pixel_y_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    if (enable) begin
      pixel_x_d  = h_q;
      pixel_y_d  = v_q;
      hsync_d    = ((h_q >= HSyncLo) && (h_q <= HSyncHi)) ? HS_POL : ~HS_POL;
      vsync_d    = ((v_q >= VSyncLo) && (v_q <= VSyncHi)) ? VS_POL : ~VS_POL;
      video_on_d = (h_q < HDisp) && (v_q < VDisp);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      pixel_tick_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_tick_q  <= tick;
      line_start_q  <= line_end;
      frame_start_q <= frame_end;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_end ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign pixel_tick  = pixel_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a tiny 7x5 raster with a divide-by-2 pixel clock.
module tb_vga_timing_gen;

  localparam int unsigned H_DISP = 4, H_FP = 1, H_SYNC = 1, H_BP = 1;
  localparam int unsigned V_DISP = 2, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int unsigned CLK_DIV = 2;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
  localparam int unsigned CW = 4;
  localparam int unsigned H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLK = H_TOT * V_TOT * CLK_DIV;

  typedef struct packed {
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic hs, vs, von, pt, ls, fs;
  } out_t;

  typedef struct {
    logic r, e;
    out_t exp;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic pixel_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [CW-1:0] pixel_x, pixel_y;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .enable     (en),
    .pixel_tick (pixel_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .line_start (line_start),
`ifdef VGA_FRAME_CNT_EN
    .frame_start(frame_start),
    .frame_count(frame_count)
`else
    .frame_start(frame_start)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0, cyc = 0;
  int   hs_ticks = 0, vs_ticks = 0, von_ticks = 0;
  int unsigned e_cnt = 0;
  out_t m_last, last_got;
  out_t exp_q[$];
  vec_t tab[20];

  function automatic out_t rst_out();
    out_t o;
    o = '0;
    o.hs = ~HS_POL;
    o.vs = ~VS_POL;
    return o;
  endfunction

  // Reference: position derived from the count of enabled clocks since reset.
  task automatic model(input logic r, input logic e, output out_t o);
    int unsigned t, h, v;
    logic tk;
    if (r) begin
      e_cnt  = 0;
      m_last = rst_out();
    end else if (!e) begin
      m_last.pt = 1'b0;
      m_last.ls = 1'b0;
      m_last.fs = 1'b0;
    end else begin
      t  = e_cnt / CLK_DIV;
      tk = ((e_cnt % CLK_DIV) == CLK_DIV - 1);
      h  = t % H_TOT;
      v  = (t / H_TOT) % V_TOT;
      m_last.px  = CW'(h);
      m_last.py  = CW'(v);
      m_last.hs  = (h >= H_DISP + H_FP && h < H_DISP + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      m_last.vs  = (v >= V_DISP + V_FP && v < V_DISP + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      m_last.von = (h < H_DISP) && (v < V_DISP);
      m_last.pt  = tk;
      m_last.ls  = tk && (h == H_TOT - 1);
      m_last.fs  = tk && (h == H_TOT - 1) && (v == V_TOT - 1);
      e_cnt++;
    end
    o = m_last;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One clock: drive at negedge, queue expectation, compare #1 after posedge.
  task automatic step_x(input logic r, input logic e, input string name,
                        input bit use_tab, input out_t tab_exp);
    out_t m, want, got;
    @(negedge clk);
    rst = r;
    en  = e;
    model(r, e, m);
    exp_q.push_back(use_tab ? tab_exp : m);
    @(posedge clk);
    #1;
    cyc++;
    got = '{px: pixel_x, py: pixel_y, hs: hsync, vs: vsync, von: video_on,
            pt: pixel_tick, ls: line_start, fs: frame_start};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got px=%0d py=%0d hs%b vs%b von%b pt%b ls%b fs%b, want px=%0d py=%0d hs%b vs%b von%b pt%b ls%b fs%b",
               name, cyc, got.px, got.py, got.hs, got.vs, got.von, got.pt, got.ls, got.fs,
               want.px, want.py, want.hs, want.vs, want.von, want.pt, want.ls, want.fs);
    end
    if (got.pt && got.hs == HS_POL) hs_ticks++;
    if (got.pt && got.vs == VS_POL) vs_ticks++;
    if (got.pt && got.von) von_ticks++;
    last_got = got;
  endtask

  task automatic step(input logic r, input logic e, input string name);
    step_x(r, e, name, 1'b0, '0);
  endtask

  task automatic run_until_fs(input int limit, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, "run_fs");
      n++;
    end while (!last_got.fs && n < limit);
    if (!last_got.fs) begin
      n_vec++;
      n_err++;
      $display("FAIL fs_timeout: got no frame_start in %0d clk, want one", limit);
    end
  endtask

  task automatic run_until_pos(input int px, input int py, input int limit, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, "run_pos");
      n++;
    end while (!(last_got.px == CW'(px) && last_got.py == CW'(py)) && n < limit);
    check_int("pos_reached", int'(last_got.px == CW'(px) && last_got.py == CW'(py)), 1);
  endtask

  function automatic vec_t mk(logic r, logic e, int px, int py, logic hs, logic vs,
                              logic von, logic pt, logic ls, logic fs);
    vec_t t;
    t.r = r;
    t.e = e;
    t.exp = '{px: CW'(px), py: CW'(py), hs: hs, vs: vs, von: von, pt: pt, ls: ls, fs: fs};
    return t;
  endfunction

  initial begin
    int n1, n2;
    //           r  e  px py hs vs von pt ls fs
    tab[0]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tab[1]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tab[2]  = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    tab[3]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    tab[4]  = mk(0, 1, 1, 0, 0, 1, 1, 1, 0, 0);
    tab[5]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tab[6]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    tab[7]  = mk(0, 1, 2, 0, 0, 1, 1, 0, 0, 0);
    tab[8]  = mk(0, 1, 2, 0, 0, 1, 1, 1, 0, 0);
    tab[9]  = mk(0, 1, 3, 0, 0, 1, 1, 0, 0, 0);
    tab[10] = mk(0, 1, 3, 0, 0, 1, 1, 1, 0, 0);
    tab[11] = mk(0, 1, 4, 0, 0, 1, 0, 0, 0, 0);
    tab[12] = mk(0, 1, 4, 0, 0, 1, 0, 1, 0, 0);
    tab[13] = mk(0, 1, 5, 0, 1, 1, 0, 0, 0, 0);
    tab[14] = mk(0, 1, 5, 0, 1, 1, 0, 1, 0, 0);
    tab[15] = mk(0, 1, 6, 0, 0, 1, 0, 0, 0, 0);
    tab[16] = mk(0, 1, 6, 0, 0, 1, 0, 1, 1, 0);
    tab[17] = mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    tab[18] = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    tab[19] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      step_x(tab[i].r, tab[i].e, $sformatf("vec%0d", i), 1'b1, tab[i].exp);
    end

    // Frame period and per-frame sync/visible tick counts.
    run_until_fs(3 * FRAME_CLK, n1);
    hs_ticks = 0; vs_ticks = 0; von_ticks = 0;
    run_until_fs(3 * FRAME_CLK, n2);
    check_int("frame_period", n2, FRAME_CLK);
    check_int("hsync_ticks", hs_ticks, H_SYNC * V_TOT);
    check_int("vsync_ticks", vs_ticks, V_SYNC * H_TOT);
    check_int("video_on_ticks", von_ticks, H_DISP * V_DISP);

    // Line period: successive line_start pulses.
    n1 = 0;
    do begin step(1'b0, 1'b1, "run_ls"); n1++; end while (!last_got.ls && n1 < 100);
    n2 = 0;
    do begin step(1'b0, 1'b1, "run_ls"); n2++; end while (!last_got.ls && n2 < 100);
    check_int("line_period", n2, H_TOT * CLK_DIV);

    // Freeze for 10 clk mid-line stretches the frame by exactly 10 clk.
    run_until_fs(3 * FRAME_CLK, n1);
    run_until_pos(3, 1, 3 * FRAME_CLK, n1);
    repeat (10) step(1'b0, 1'b0, "freeze");
    run_until_fs(3 * FRAME_CLK, n2);
    check_int("frozen_frame_period", n1 + 10 + n2, FRAME_CLK + 10);

    // Reset mid-frame; first frame_start exactly one frame later.
    run_until_pos(2, 2, 3 * FRAME_CLK, n1);
    step(1'b1, 1'b1, "mid_reset");
    check_int("reset_px", int'(pixel_x), 0);
    run_until_fs(3 * FRAME_CLK, n2);
    check_int("post_reset_fs", n2, FRAME_CLK);

    // Random enable/reset mix against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
